rns_result_fifo_sel: RTL and testbench

- Parametrised successor to the RNS ALU result multiplexer.
- Selects the add, sub or mul residue vector for CH_NUM RNS channels using a 2-bit op code.
- Flags the reserved op code and buffers results in a small FIFO with valid/ready handshakes on both sides.
- Sits between the per-channel RNS arithmetic units and the reverse-converter / output stage.

---
 rtl/rns_pkg.sv | 13 +
 rtl/rns_sync_fifo.sv | 41 ++++
 rtl/rns_result_fifo_sel.sv | 66 ++++++
 tb/tb_rns_result_fifo_sel.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// rns_pkg: shared RNS op codes, default channel geometry and vector slicing helper
package rns_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam int RNS_CH_NUM = 3;
  localparam int RNS_RES_W  = 7;
  // channel k of a packed residue vector lives at bits [ch_lsb(k, res_w) +: res_w]
  function automatic int ch_lsb(input int k, input int res_w);
    return k * res_w;
  endfunction
endpackage

// File: rtl/rns_sync_fifo.sv
// rns_sync_fifo: generic width/depth FIFO with occupancy count, sync flush, async active-low reset
// Ports: clk, rst_n; i_flush clears pointers/count; i_push writes i_data; i_pop advances the read side;
//        o_data is the head entry (zero when empty); o_count is the occupancy.
// The caller qualifies i_push/i_pop with its own full/empty handshakes. DEPTH must be a power of 2.
module rns_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  always_ff @(posedge clk)
    if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
  // zero head when empty so the output reads all-zero out of reset and after flush
  assign o_data  = r_count != '0 ? r_mem[r_rptr] : '0;
  assign o_count = r_count;
endmodule

// File: rtl/rns_result_fifo_sel.sv
// rns_result_fifo_sel: selects add/sub/mul RNS residue vector by op code, flags reserved op, buffers in a FIFO
// Ports: clk, rst_n (async active-low); in_valid/in_ready, op_sel, add_res/sub_res/mul_res (input side);
//        flush (sync clear); out_valid/out_ready, out_res, out_err (output side).
// Optional: define RNS_ERR_CNT_EN to add err_cnt[15:0], a saturating count of reserved-op pushes.
module rns_result_fifo_sel
  import rns_pkg::*;
#(
  parameter int CH_NUM = RNS_CH_NUM,
  parameter int RES_W  = RNS_RES_W,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              op_sel,
  input  logic [CH_NUM*RES_W-1:0] add_res,
  input  logic [CH_NUM*RES_W-1:0] sub_res,
  input  logic [CH_NUM*RES_W-1:0] mul_res,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_NUM*RES_W-1:0] out_res,
  output logic                    out_err
`ifdef RNS_ERR_CNT_EN
  ,
  output logic [15:0]             err_cnt
`endif
);
  localparam int VW = CH_NUM * RES_W;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [VW-1:0] w_sel;
  logic          w_err, w_push, w_pop;
  logic [CW-1:0] w_count;
  logic [VW:0]   w_rd;
  // whole-vector select applies the same choice to every channel
  always_comb begin
    w_sel = op_sel == OP_ADD ? add_res :
            op_sel == OP_SUB ? sub_res :
            op_sel == OP_MUL ? mul_res : '0;
    w_err = op_sel == OP_RSV;
  end
  assign in_ready  = w_count != CW'(DEPTH);
  assign out_valid = w_count != '0;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign {out_err, out_res} = w_rd;
  rns_sync_fifo #(.W(VW + 1), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  ({w_err, w_sel}),
    .i_pop   (w_pop),
    .o_data  (w_rd),
    .o_count (w_count)
  );
`ifdef RNS_ERR_CNT_EN
  logic [15:0] r_err_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_err_cnt <= '0;
    else if (flush) r_err_cnt <= '0;
    else if (w_push && w_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
  assign err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_rns_result_fifo_sel.sv
// tb_rns_result_fifo_sel: table-driven and scoreboard bench for rns_result_fifo_sel
module tb_rns_result_fifo_sel;
  localparam int RW = 7;
  localparam int VW = 3 * RW;
  localparam int DEPTH = 2;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_err;
  logic [1:0] op_sel = 2'b00;
  logic [VW-1:0] add_res = '0, sub_res = '0, mul_res = '0, out_res;
`ifdef RNS_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif
  always #5 clk = ~clk;

  rns_result_fifo_sel #(.CH_NUM(3), .RES_W(RW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sel    (op_sel),
    .add_res   (add_res),
    .sub_res   (sub_res),
    .mul_res   (mul_res),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_err   (out_err)
`ifdef RNS_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  typedef struct {
    logic [1:0]    op;
    logic [VW-1:0] a, s, m, exp;
    logic          err;
  } vec_t;

  vec_t tbl[8];
  logic [VW:0] q[$];
  logic [VW-1:0] drv_res, hold_res;
  logic drv_err, hold_err, stall_prev = 1'b0, mon_en = 1'b0;
  int n_chk = 0, n_pass = 0, n_pop = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [VW-1:0] a, s, m, exp, input logic err);
    vec_t v;
    v.op = op; v.a = a; v.s = s; v.m = m; v.exp = exp; v.err = err;
    return v;
  endfunction

  function automatic vec_t model(input logic [1:0] op, input logic [VW-1:0] a, s, m);
    case (op)
      2'b00: return mk(op, a, s, m, a, 1'b0);
      2'b01: return mk(op, a, s, m, s, 1'b0);
      2'b10: return mk(op, a, s, m, m, 1'b0);
      default: return mk(op, a, s, m, '0, 1'b1);
    endcase
  endfunction

  task automatic send(input vec_t v);
    op_sel = v.op; add_res = v.a; sub_res = v.s; mul_res = v.m;
    drv_res = v.exp; drv_err = v.err;
    in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // scoreboard monitor: decides at the negedge which handshakes the next posedge will take
  always @(negedge clk) if (mon_en && rst_n) begin
    logic [VW:0] e;
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() != DEPTH);
    if (stall_prev) begin
      chk("hold_res", out_res, hold_res);
      chk("hold_err", out_err, hold_err);
    end
    stall_prev = out_valid && !out_ready && !flush;
    hold_res = out_res;
    hold_err = out_err;
    if (flush) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("pop_unexpected", out_valid, 1'b0);
        else begin
          e = q.pop_front();
          chk("out_res", out_res, e[VW-1:0]);
          chk("out_err", out_err, e[VW]);
          n_pop++;
        end
      end
      if (in_valid && in_ready) q.push_back({drv_err, drv_res});
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nrsv, p0;
    vec_t v;
    tbl[0] = mk(2'b00, {7'd10, 7'd20, 7'd30}, {7'd1, 7'd2, 7'd3}, {7'd4, 7'd5, 7'd6}, {7'd10, 7'd20, 7'd30}, 1'b0);
    tbl[1] = mk(2'b01, {7'd11, 7'd12, 7'd13}, {7'd5, 7'd3, 7'd1}, {7'd7, 7'd8, 7'd9}, {7'd5, 7'd3, 7'd1}, 1'b0);
    tbl[2] = mk(2'b10, {7'd1, 7'd1, 7'd1}, {7'd2, 7'd2, 7'd2}, {7'd127, 7'd0, 7'd64}, {7'd127, 7'd0, 7'd64}, 1'b0);
    tbl[3] = mk(2'b11, {7'd9, 7'd8, 7'd7}, {7'd6, 7'd5, 7'd4}, {7'd3, 7'd2, 7'd1}, {7'd0, 7'd0, 7'd0}, 1'b1);
    tbl[4] = mk(2'b00, {7'd127, 7'd127, 7'd127}, {7'd0, 7'd0, 7'd0}, {7'd0, 7'd0, 7'd0}, {7'd127, 7'd127, 7'd127}, 1'b0);
    tbl[5] = mk(2'b11, {7'd127, 7'd127, 7'd127}, {7'd127, 7'd127, 7'd127}, {7'd127, 7'd127, 7'd127}, {7'd0, 7'd0, 7'd0}, 1'b1);
    tbl[6] = mk(2'b10, {7'd50, 7'd51, 7'd52}, {7'd60, 7'd61, 7'd62}, {7'd99, 7'd98, 7'd97}, {7'd99, 7'd98, 7'd97}, 1'b0);
    tbl[7] = mk(2'b01, {7'd127, 7'd0, 7'd127}, {7'd0, 7'd127, 7'd0}, {7'd33, 7'd34, 7'd35}, {7'd0, 7'd127, 7'd0}, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_res", out_res, '0);
    chk("rst_out_err", out_err, 1'b0);
`ifdef RNS_ERR_CNT_EN
    chk("rst_err_cnt", err_cnt, 16'd0);
`endif
    mon_en = 1'b1;
    @(posedge clk); #1;
    // single push, one-cycle latency, empty after one pop
    out_ready = 1'b1;
    send(tbl[1]);
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_res", out_res, {7'd5, 7'd3, 7'd1});
    chk("lat_err", out_err, 1'b0);
    idle(1);
    chk("empty_after_pop", out_valid, 1'b0);
    // table-driven selection patterns
    nrsv = 0;
    for (int i = 0; i < 8; i++) begin
      send(tbl[i]);
      if (tbl[i].op == 2'b11) nrsv++;
    end
    idle(2);
`ifdef RNS_ERR_CNT_EN
    chk("err_cnt_table", err_cnt, 16'(nrsv));
`endif
    // backpressure: fill, try a third push, then drain in order
    out_ready = 1'b0;
    send(tbl[0]);
    send(tbl[2]);
    chk("full_in_ready", in_ready, 1'b0);
    send(tbl[3]);
    chk("full_still", in_ready, 1'b0);
    chk("full_head", out_res, {7'd10, 7'd20, 7'd30});
    idle(2);
    out_ready = 1'b1;
    idle(3);
    chk("drained", out_valid, 1'b0);
    // continuous streaming, cycling add/sub/mul
    p0 = n_pop;
    for (int i = 0; i < 20; i++)
      send(model(2'(i % 3), VW'($urandom), VW'($urandom), VW'($urandom)));
    idle(2);
    chk("stream_pops", n_pop - p0, 20);
    // flush with two entries held and a concurrent push
    out_ready = 1'b0;
    send(tbl[3]);
    send(tbl[6]);
    flush = 1'b1;
    send(tbl[4]);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
`ifdef RNS_ERR_CNT_EN
    chk("flush_err_cnt", err_cnt, 16'd0);
    out_ready = 1'b1;
    send(tbl[5]);
    chk("err_cnt_inc", err_cnt, 16'd1);
`endif
    out_ready = 1'b1;
    idle(2);
    // async reset between edges with an entry held
    out_ready = 1'b0;
    send(tbl[7]);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    q.delete();
    stall_prev = 1'b0;
    #1;
    chk("arst_valid_low", out_valid, 1'b0);
    rst_n = 1'b1;
    #0;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_res", out_res, '0);
    out_ready = 1'b1;
    idle(3);
    send(tbl[0]);
    idle(2);
    chk("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
